// File: rtl/rs_alu_pkg.sv
// Shared entry type and helpers for the ALU reservation station.
// The entry layout is sized by the package widths, and rs_alu's parameters default to them.
package rs_pkg;

  localparam int unsigned RS_OP_W   = 8;
  localparam int unsigned RS_TAG_W  = 5;
  localparam int unsigned RS_DATA_W = 32;

  localparam logic [RS_TAG_W-1:0] TAG_NONE = '0;

  typedef struct packed {
    logic                           valid;
    logic [RS_OP_W-1:0]             op;
    logic [1:2][RS_TAG_W-1:0]       tag;
    logic [1:2][RS_DATA_W-1:0]      val;
    logic [RS_TAG_W-1:0]            target;
  } rs_entry_t;

  typedef enum logic [1:0] {
    SRC_HOLD  = 2'd0,
    SRC_SHIFT = 2'd1,
    SRC_LOAD  = 2'd2
  } rs_src_e;

  function automatic logic rs_ready(input rs_entry_t e);
    return e.valid && (e.tag[1] == TAG_NONE) && (e.tag[2] == TAG_NONE);
  endfunction

endpackage

// File: rtl/rs_alu_slot.sv
// One reservation-station entry: source mux (hold / shift-down / new) followed by CDB capture.
module rs_slot
  import rs_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  rs_src_e              sel,
  input  rs_entry_t            upper_i,
  input  rs_entry_t            new_i,
  input  logic                 cdb_valid,
  input  logic [RS_TAG_W-1:0]  cdb_tag,
  input  logic [RS_DATA_W-1:0] cdb_val,
  output rs_entry_t            entry_o
);

  rs_entry_t entry_q, entry_d, src;

  // The CDB compare sits after the mux, so shifted copies and incoming entries are woken alike.
  always_comb begin
    src = entry_q;
    unique case (sel)
      SRC_SHIFT: src = upper_i;
      SRC_LOAD:  src = new_i;
      default:   src = entry_q;
    endcase
    entry_d = src;
    if (cdb_valid && (cdb_tag != TAG_NONE) && src.valid) begin
      for (int unsigned k = 1; k <= 2; k++) begin
        if (src.tag[k] == cdb_tag) begin
          entry_d.tag[k] = TAG_NONE;
          entry_d.val[k] = cdb_val;
        end
      end
    end
    if (flush) entry_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) entry_q <= '0;
    else     entry_q <= entry_d;
  end

  assign entry_o = entry_q;

endmodule

// File: rtl/rs_alu.sv
// Reservation station for one ALU: compacting age-ordered queue with CDB wakeup and a registered issue slot.
module rs_alu
  import rs_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned OP_W   = RS_OP_W,
  parameter int unsigned TAG_W  = RS_TAG_W,
  parameter int unsigned DATA_W = RS_DATA_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [OP_W-1:0]            in_op,
  input  logic [TAG_W-1:0]           in_tag1,
  input  logic [TAG_W-1:0]           in_tag2,
  input  logic [DATA_W-1:0]          in_val1,
  input  logic [DATA_W-1:0]          in_val2,
  input  logic [TAG_W-1:0]           in_target,
  input  logic                       cdb_valid,
  input  logic [TAG_W-1:0]           cdb_tag,
  input  logic [DATA_W-1:0]          cdb_val,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OP_W-1:0]            out_op,
  output logic [DATA_W-1:0]          out_val1,
  output logic [DATA_W-1:0]          out_val2,
  output logic [TAG_W-1:0]           out_target,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  rs_entry_t slot_e [DEPTH];
  rs_entry_t upper  [DEPTH];
  rs_src_e   sel    [DEPTH];
  rs_entry_t new_e;

  logic [CNT_W-1:0]  count_q, count_d, wr_idx;
  logic [IDX_W-1:0]  pick;
  logic              found, issue_en, accept;

  logic              out_valid_q, out_valid_d;
  logic [OP_W-1:0]   out_op_q, out_op_d;
  logic [DATA_W-1:0] out_val1_q, out_val1_d, out_val2_q, out_val2_d;
  logic [TAG_W-1:0]  out_target_q, out_target_d;

  assign in_ready = !rst && !flush && (count_q < CNT_W'(DEPTH));
  assign accept   = in_valid && in_ready;

  always_comb begin
    new_e        = '0;
    new_e.valid  = 1'b1;
    new_e.op     = in_op;
    new_e.tag[1] = in_tag1;
    new_e.tag[2] = in_tag2;
    new_e.val[1] = in_val1;
    new_e.val[2] = in_val2;
    new_e.target = in_target;
  end

  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!found && rs_ready(slot_e[i])) begin
        found = 1'b1;
        pick  = IDX_W'(i);
      end
    end
    issue_en = found && (!out_valid_q || out_ready);
  end

  // With an issue the queue shrinks by one first, so the new entry lands at count-1.
  always_comb begin
    wr_idx = issue_en ? count_q - CNT_W'(1) : count_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      sel[i] = SRC_HOLD;
      if (accept && (wr_idx == CNT_W'(i)))        sel[i] = SRC_LOAD;
      else if (issue_en && (IDX_W'(i) >= pick))   sel[i] = SRC_SHIFT;
    end
  end

  always_comb begin
    count_d = count_q;
    if (flush)                     count_d = '0;
    else if (accept && !issue_en)  count_d = count_q + CNT_W'(1);
    else if (!accept && issue_en)  count_d = count_q - CNT_W'(1);
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_op_d     = out_op_q;
    out_val1_d   = out_val1_q;
    out_val2_d   = out_val2_q;
    out_target_d = out_target_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (issue_en) begin
      out_valid_d  = 1'b1;
      out_op_d     = slot_e[pick].op;
      out_val1_d   = slot_e[pick].val[1];
      out_val2_d   = slot_e[pick].val[2];
      out_target_d = slot_e[pick].target;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q      <= '0;
      out_valid_q  <= 1'b0;
      out_op_q     <= '0;
      out_val1_q   <= '0;
      out_val2_q   <= '0;
      out_target_q <= '0;
    end else begin
      count_q      <= count_d;
      out_valid_q  <= out_valid_d;
      out_op_q     <= out_op_d;
      out_val1_q   <= out_val1_d;
      out_val2_q   <= out_val2_d;
      out_target_q <= out_target_d;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    if (g < DEPTH - 1) begin : g_up
      assign upper[g] = slot_e[g+1];
    end else begin : g_top
      assign upper[g] = '0;
    end

    rs_slot u_slot (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .sel       (sel[g]),
      .upper_i   (upper[g]),
      .new_i     (new_e),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_val   (cdb_val),
      .entry_o   (slot_e[g])
    );
  end

  assign out_valid  = out_valid_q;
  assign out_op     = out_op_q;
  assign out_val1   = out_val1_q;
  assign out_val2   = out_val2_q;
  assign out_target = out_target_q;
  assign count      = count_q;

endmodule
